multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//   Multi-cycle control FSM that sequences the core datapath (PC, instruction memory, register
//   file, ALU) through FETCH/DECODE/EXECUTE/WRITEBACK. It replaces free-running single-cycle
//   stepping and makes the following behaviours explicit and observable:
//   - variable-latency instruction fetch, using a req/ack handshake;
//   - halt detection;
//   - traps on unsupported opcodes, ALU overflow and fetch timeout.
//   It drives the enables only: PC advance, IR load and RF write. ALUOp still comes from Control.
// PARAMETERS
//   PC_WIDTH      6      width of the PC. Used only for the trap_pc capture.
//   HALT_OPCODE   6'h3F  opcode that stops execution.
//   FETCH_TIMEOUT 8      maximum number of FETCH cycles without imem_ack before a trap (>=2).
//   CNT_WIDTH     16     width of the retired-instruction counter.
// PORTS
//   clk           in   1          system clock; all state updates on the rising edge.
//   rst           in   1          synchronous reset, active-low (0 = reset).
//   run           in   1          1 = execute instructions; 0 = finish the current instruction, then idle.
//   opcode        in   6          Instruction[31:26] from the instruction memory/IR.
//   pc            in   PC_WIDTH   current PC value; captured on a trap.
//   alu_overflow  in   1          ALU overflow flag, sampled in EXECUTE.
//   imem_ack      in   1          instruction memory has valid data this cycle.
//   imem_req      out  1          fetch request; high for every cycle in FETCH.
//   ir_load       out  1          1-cycle pulse; latch the instruction (FETCH and imem_ack).
//   rf_we         out  1          register-file write enable; high in WRITEBACK only.
//   pc_en         out  1          PC advance (PC <= PC_next); high in WRITEBACK only.
//   state         out  3          IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 HALT=5 TRAP=6.
//   busy          out  1          1 in FETCH, DECODE, EXECUTE and WRITEBACK.
//   halted        out  1          1 in HALT.
//   trap_cause    out  2          0=none 1=illegal opcode 2=fetch timeout 3=overflow.
//   trap_pc       out  PC_WIDTH  value of pc when the trap was taken.
//   retired       out  CNT_WIDTH  number of completed WRITEBACKs; saturates at all-ones.
// BEHAVIOUR
//   Reset (rst==0 at a clk edge): state=IDLE; trap_cause=0; trap_pc=0; retired=0;
//     timeout counter=0. All strobes deassert in the same edge. Reset overrides any state,
//     including mid-instruction, HALT and TRAP.
//   Strobes (imem_req, ir_load, rf_we, pc_en) are Moore or state-qualified outputs. They are
//     never asserted in IDLE, HALT or TRAP.
//   IDLE:      run=1 -> FETCH; otherwise stay.
//   FETCH:     imem_req=1; the timeout counter increments each cycle without an ack.
//              - imem_ack=1: ir_load=1 this cycle, counter cleared, -> DECODE.
//              - no ack and counter==FETCH_TIMEOUT-1: -> TRAP, cause=2.
//              - ack and timeout in the same cycle: the ack wins.
//              - run is ignored in this state.
//   DECODE:    opcode==HALT_OPCODE -> HALT (no write, PC not advanced).
//              opcode!=6'h00 (only R-type is supported) -> TRAP, cause=1.
//              otherwise -> EXECUTE.
//   EXECUTE:   one cycle for the ALU operands to settle.
//              - alu_overflow=1 -> TRAP, cause=3; rf_we and pc_en are never raised.
//              - otherwise -> WRITEBACK.
//   WRITEBACK: rf_we=1, pc_en=1, retired += 1 (saturating).
//              Next state is FETCH if run=1, else IDLE.
//   HALT, TRAP: absorbing states; only a reset leaves them.
//              trap_pc and trap_cause are loaded on the entry edge and then held.
//   Throughput: a zero-wait-state fetch (ack in the first FETCH cycle) gives 4 cycles per
//     instruction. Each wait cycle adds 1 cycle.
//   PC wrap-around is owned by the PC/Adder blocks; the sequencer only pulses pc_en.
// TESTING
//   1. rst=0 for 2 cycles, then rst=1, run=1, opcode=0, imem_ack tied 1:
//      state sequence 0,1,2,3,4,1,...; rf_we/pc_en high every 4th cycle; retired=3 after 12
//      cycles from FETCH entry.
//   2. imem_ack held 0 for 3 FETCH cycles, then 1: imem_req high for 4 cycles; ir_load pulses
//      once in cycle 4; trap_cause stays 0.
//   3. imem_ack never asserted, FETCH_TIMEOUT=8: after 8 FETCH cycles state=6, trap_cause=2,
//      trap_pc=pc; the FSM stays in TRAP for 20 more cycles.
//   4. opcode=6'h3F in DECODE -> state=5, halted=1; no rf_we or pc_en pulse.
//      opcode=6'h08 -> state=6, trap_cause=1.
//   5. alu_overflow=1 in EXECUTE -> state=6, trap_cause=3, rf_we never high, retired unchanged.
//   6. run dropped in DECODE -> the instruction completes (rf_we pulses), then state=0.
//      rst pulled low in EXECUTE -> state=0 and retired=0 at the next edge.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the core datapath: sequences FETCH/DECODE/EXECUTE/WRITEBACK,
// handles the imem req/ack handshake, halt detection, traps and the retired-instruction count.
module multicycle_sequencer #(
  parameter int unsigned PC_WIDTH      = 6,
  parameter logic [5:0]  HALT_OPCODE   = 6'h3F,
  parameter int unsigned FETCH_TIMEOUT = 8,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 alu_overflow,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 rf_we,
  output logic                 pc_en,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [PC_WIDTH-1:0]  trap_pc,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int unsigned TO_W = $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  state_e                state_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [1:0]            trap_cause_q;
  logic [PC_WIDTH-1:0]   trap_pc_q;
  logic [CNT_WIDTH-1:0]  retired_q;

  // Sequencer state, fetch timeout counter, trap capture and retired counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= '0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
      retired_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          // An ack arriving on the last allowed cycle still wins over the timeout.
          if (imem_ack) begin
            state_q  <= S_DECODE;
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q      <= S_TRAP;
            to_cnt_q     <= '0;
            trap_cause_q <= CAUSE_TIMEOUT;
            trap_pc_q    <= pc;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (opcode == HALT_OPCODE) begin
            state_q <= S_HALT;
          end else if (opcode != 6'h00) begin
            state_q      <= S_TRAP;
            trap_cause_q <= CAUSE_ILLEGAL;
            trap_pc_q    <= pc;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (alu_overflow) begin
            state_q      <= S_TRAP;
            trap_cause_q <= CAUSE_OVERFLOW;
            trap_pc_q    <= pc;
          end else begin
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if (retired_q != '1) retired_q <= retired_q + CNT_WIDTH'(1);
          state_q <= run ? S_FETCH : S_IDLE;
        end
        default: begin
          // HALT and TRAP are absorbing; only reset leaves them.
          state_q <= state_q;
        end
      endcase
    end
  end

  // Strobes are decoded from the state register; ir_load is additionally qualified by ack.
  assign imem_req   = (state_q == S_FETCH);
  assign ir_load    = (state_q == S_FETCH) && imem_ack;
  assign rf_we      = (state_q == S_WRITEBACK);
  assign pc_en      = (state_q == S_WRITEBACK);
  assign state      = state_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted     = (state_q == S_HALT);
  assign trap_cause = trap_cause_q;
  assign trap_pc    = trap_pc_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer: normal flow, fetch waits,
// timeout, halt, illegal opcode, overflow, run drop and mid-instruction reset.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  pc;
  logic        alu_overflow;
  logic        imem_ack;
  logic        imem_req;
  logic        ir_load;
  logic        rf_we;
  logic        pc_en;
  logic [2:0]  state;
  logic        busy;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [5:0]  trap_pc;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .pc           (pc),
    .alu_overflow (alu_overflow),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .rf_we        (rf_we),
    .pc_en        (pc_en),
    .state        (state),
    .busy         (busy),
    .halted       (halted),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst          = 1'b0;
    run          = 1'b0;
    imem_ack     = 1'b0;
    opcode       = 6'h00;
    pc           = 6'h00;
    alu_overflow = 1'b0;
    step();
    step();
    check({tag, "_rst_state"}, 32'(state), 32'd0);
    check({tag, "_rst_retired"}, 32'(retired), 32'd0);
    check({tag, "_rst_cause"}, 32'(trap_cause), 32'd0);
    check({tag, "_rst_tpc"}, 32'(trap_pc), 32'd0);
    check({tag, "_rst_strobes"}, 32'({imem_req, ir_load, rf_we, pc_en, busy, halted}), 32'd0);
  endtask

  initial begin
    // 1: zero-wait fetch, continuous execution
    do_reset("t1");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h00;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t1_state_c%0d", k), 32'(state), 32'((k % 4) + 1));
      check($sformatf("t1_we_c%0d", k), 32'({rf_we, pc_en}), (k % 4 == 3) ? 32'd3 : 32'd0);
      check($sformatf("t1_ret_c%0d", k), 32'(retired), 32'(k / 4));
    end
    step();
    check("t1_ret_final", 32'(retired), 32'd3);
    check("t1_state_final", 32'(state), 32'd1);

    // 2: three wait cycles then ack
    do_reset("t2");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      imem_ack = (c == 4);
      #1;
      check($sformatf("t2_req_c%0d", c), 32'(imem_req), 32'd1);
      check($sformatf("t2_irl_c%0d", c), 32'(ir_load), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("t2_state_c%0d", c), 32'(state), 32'd1);
      check($sformatf("t2_cause_c%0d", c), 32'(trap_cause), 32'd0);
    end
    step();
    check("t2_decode", 32'(state), 32'd2);
    check("t2_req_off", 32'({imem_req, ir_load}), 32'd0);

    // 3: fetch timeout
    do_reset("t3");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b0; pc = 6'h2A;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("t3_fetch_c%0d", c), 32'(state), 32'd1);
    end
    step();
    check("t3_trap_state", 32'(state), 32'd6);
    check("t3_trap_cause", 32'(trap_cause), 32'd2);
    check("t3_trap_pc", 32'(trap_pc), 32'h2A);
    pc = 6'h15; imem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("t3_hold_c%0d", c),
            32'({state, trap_cause, trap_pc, imem_req, ir_load, rf_we, pc_en, busy}),
            32'({3'd6, 2'd2, 6'h2A, 5'd0}));
    end

    // 4a: halt opcode
    do_reset("t4a");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h3F;
    step(); step();
    check("t4a_decode", 32'(state), 32'd2);
    step();
    check("t4a_halt_state", 32'(state), 32'd5);
    check("t4a_halted", 32'({halted, busy}), 32'd2);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("t4a_hold_c%0d", c),
            32'({state, rf_we, pc_en, imem_req, retired}), 32'({3'd5, 3'd0, 16'd0}));
    end

    // 4b: illegal opcode
    do_reset("t4b");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h08; pc = 6'h11;
    step(); step(); step();
    check("t4b_state", 32'(state), 32'd6);
    check("t4b_cause", 32'(trap_cause), 32'd1);
    check("t4b_tpc", 32'(trap_pc), 32'h11);

    // 5: overflow in EXECUTE
    do_reset("t5");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h00; alu_overflow = 1'b1; pc = 6'h07;
    step(); step(); step();
    check("t5_exec", 32'(state), 32'd3);
    step();
    check("t5_state", 32'(state), 32'd6);
    check("t5_cause", 32'(trap_cause), 32'd3);
    check("t5_tpc", 32'(trap_pc), 32'h07);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t5_hold_c%0d", c), 32'({rf_we, pc_en, retired}), 32'd0);
    end

    // 6a: run dropped in DECODE completes the instruction, then idles
    do_reset("t6a");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h00;
    step(); step();
    check("t6a_decode", 32'(state), 32'd2);
    run = 1'b0;
    step();
    check("t6a_exec", 32'(state), 32'd3);
    step();
    check("t6a_wb", 32'({state, rf_we, pc_en}), 32'({3'd4, 2'b11}));
    step();
    check("t6a_idle", 32'(state), 32'd0);
    check("t6a_ret", 32'(retired), 32'd1);
    step(); step();
    check("t6a_idle_hold", 32'({state, imem_req, busy}), 32'd0);

    // 6b: reset asserted mid-instruction
    do_reset("t6b");
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; opcode = 6'h00;
    repeat (7) step();
    check("t6b_exec", 32'(state), 32'd3);
    check("t6b_ret_pre", 32'(retired), 32'd1);
    rst = 1'b0;
    step();
    check("t6b_state", 32'(state), 32'd0);
    check("t6b_ret", 32'(retired), 32'd0);
    check("t6b_we", 32'({rf_we, pc_en}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
